shift_sequencer: RTL

- Multi-cycle rotate/shift sequencer for the V30MZ execution unit. Performs the shift-group instructions (ROL, ROR, ROLC, RORC, SHL, SHR, SHRA) with a register or CL count, one bit position per clock.
- Produces the result, CF and OF, plus a flag write-enable for the flag register.
- Sits beside the alu. The microsequencer issues a request with a start pulse and waits for done.

---
 rtl/shift_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle ROL/ROR/ROLC/RORC/SHL/SHR/SHRA engine, one bit per clock, 8- or 16-bit.
module shift_sequencer #(
  parameter int MAX_COUNT_BITS = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [3:0]                op,
  input  logic                      word,
  input  logic [15:0]               operand,
  input  logic [MAX_COUNT_BITS-1:0] count,
  input  logic                      carry_in,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               result,
  output logic                      carry_out,
  output logic                      overflow_out,
  output logic                      flags_we,
  output logic                      err
);
  localparam logic [3:0] ROL  = 4'd6;
  localparam logic [3:0] ROR  = 4'd7;
  localparam logic [3:0] ROLC = 4'd8;
  localparam logic [3:0] RORC = 4'd9;
  localparam logic [3:0] SHL  = 4'd10;
  localparam logic [3:0] SHR  = 4'd11;
  localparam logic [3:0] SHRA = 4'd12;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]                st;
  logic [3:0]                op_q;
  logic                      word_q;
  logic [15:0]               val;
  logic [MAX_COUNT_BITS-1:0] cnt_q;
  logic                      c_q;
  logic                      illegal;
  logic                      left;
  logic                      msb_in;
  logic                      ins_l;
  logic                      ins_r;
  logic [15:0]               sh_l;
  logic [15:0]               sh_r;
  logic [15:0]               nv;
  logic                      nc;
  logic                      msb_out;
  logic                      msb1_out;
  logic                      of;

  assign busy    = (st == RUN);
  assign illegal = (op < ROL) || (op > SHRA);

  // Byte mode shifts only [7:0]; the high byte rides through untouched.
  always_comb begin
    left     = (op_q == ROL) || (op_q == ROLC) || (op_q == SHL);
    msb_in   = word_q ? val[15] : val[7];
    ins_l    = (op_q == ROL) ? msb_in : (op_q == ROLC) ? c_q : 1'b0;
    ins_r    = (op_q == ROR) ? val[0] : (op_q == RORC) ? c_q : (op_q == SHRA) ? msb_in : 1'b0;
    sh_l     = word_q ? {val[14:0], ins_l} : {val[15:8], val[6:0], ins_l};
    sh_r     = word_q ? {ins_r, val[15:1]} : {val[15:8], ins_r, val[7:1]};
    nv       = left ? sh_l : sh_r;
    nc       = left ? msb_in : val[0];
    msb_out  = word_q ? nv[15] : nv[7];
    msb1_out = word_q ? nv[14] : nv[6];
    of       = left ? (msb_out ^ nc) :
               ((op_q == ROR) || (op_q == RORC)) ? (msb_out ^ msb1_out) :
               (op_q == SHR) ? msb_in : 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st           <= IDLE;
      op_q         <= '0;
      word_q       <= 1'b0;
      val          <= '0;
      cnt_q        <= '0;
      c_q          <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      carry_out    <= 1'b0;
      overflow_out <= 1'b0;
      flags_we     <= 1'b0;
      err          <= 1'b0;
    end else begin
      done     <= 1'b0;
      flags_we <= 1'b0;
      err      <= 1'b0;
      if (st == IDLE) begin
        if (start) begin
          op_q   <= op;
          word_q <= word;
          val    <= operand;
          cnt_q  <= count;
          c_q    <= carry_in;
          if (illegal || count == '0) begin
            done         <= 1'b1;
            err          <= illegal;
            result       <= operand;
            carry_out    <= carry_in;
            overflow_out <= 1'b0;
          end else begin
            st <= RUN;
          end
        end
      end else begin
        val   <= nv;
        c_q   <= nc;
        cnt_q <= cnt_q - MAX_COUNT_BITS'(1);
        if (cnt_q == MAX_COUNT_BITS'(1)) begin
          st           <= IDLE;
          done         <= 1'b1;
          flags_we     <= 1'b1;
          result       <= nv;
          carry_out    <= nc;
          overflow_out <= of;
        end
      end
    end
  end
endmodule
